ahb_apb_bridge_gen2: RTL and testbench
======================================

Name: ahb_apb_bridge_gen2

Overview:
Parametrised next-generation AHB-to-APB bridge. It sits between the AHB system bus and a group of NUM_SLV APB peripherals. It converts single AHB transfers into APB3 SETUP/ACCESS sequences and honours peripheral wait states (pready). Peripheral errors (pslverr), address-decode misses and wait-state timeouts are all reported as the two-cycle AHB ERROR response.

Parameters:
ADDR_W, 32, address width of haddr/paddr
DATA_W, 32, data width of hwdata/hrdata/pwdata/prdata
NUM_SLV, 4, number of APB slaves; psel width; legal range 1..16
SLV_SHIFT, 12, haddr bit where the slave index field starts; slave window = 2^SLV_SHIFT bytes
BASE_ADDR, 32'h8000_0000, base of the bridge region; must be aligned to NUM_SLV*2^SLV_SHIFT
TIMEOUT, 255, max ACCESS cycles waiting for pready before abort; 0 disables timeout

Ports:
hclk  in  1  clock
hresetn  in  1  reset, synchronous, active-low
hwrite  in  1  AHB write/read
hready_in  in  1  AHB bus ready
htrans  in  2  AHB transfer type
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data, valid in the data phase
hrdata  out  DATA_W  AHB read data
hr_readyout  out  1  bridge ready to AHB
hresp  out  2  00 OKAY, 01 ERROR
psel  out  NUM_SLV  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  shared APB read data bus
pready  in  1  selected-slave ready
pslverr  in  1  selected-slave error

Behaviour:
- One clock, hclk. Reset is synchronous and active-low on hresetn. When hresetn=0 at a hclk edge: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hr_readyout=1, hresp=00, timeout counter=0.
- Reset mid-transfer aborts the APB access immediately. psel and penable drop on the same edge. No response is given to AHB.
- Valid transfer: hready_in=1 and htrans is NONSEQ(10) or SEQ(11), sampled in IDLE or ERR2. IDLE(00) and BUSY(01) are ignored.
- Decode: in range when haddr - BASE_ADDR < NUM_SLV*2^SLV_SHIFT (unsigned). Slave index = haddr[SLV_SHIFT +: clog2(NUM_SLV)].
- On accept: latch haddr, hwrite and the slave index. Next state:
  - out of range -> ERR1
  - write -> WDATA
  - read -> SETUP
- States and outputs:
  - IDLE: hr_readyout=1, hresp=00, psel=0, penable=0.
  - WDATA: hr_readyout=0. Capture hwdata into pwdata. Next state SETUP.
  - SETUP: psel[idx]=1, penable=0, paddr/pwrite valid, hr_readyout=0. Next state ACCESS. Timeout counter cleared.
  - ACCESS: psel[idx]=1, penable=1, hr_readyout=0. Counter increments each cycle pready=0.
    - pready=1 and pslverr=0: for reads, hrdata<=prdata. Next state IDLE; the transfer completes in that IDLE cycle with hr_readyout=1.
    - pready=1 and pslverr=1: next state ERR1; hrdata not updated.
    - TIMEOUT!=0 and counter reaches TIMEOUT with pready=0: next state ERR1. psel and penable drop.
  - ERR1: hresp=01, hr_readyout=0, psel=0. Next state ERR2.
  - ERR2: hresp=01, hr_readyout=1. Accepts a new transfer exactly as IDLE does; otherwise next state IDLE.
- paddr, pwrite and pwdata hold stable from SETUP through the final ACCESS cycle. paddr holds its value while idle.
- Latency with zero APB wait states:
  - read: address phase + 3 cycles to the hr_readyout=1 completion cycle
  - write: address phase + 4 cycles to completion
  - each pready=0 cycle adds 1.
- Back-to-back: the completion cycle (IDLE with hr_readyout=1) accepts the next address, so no idle bubble is inserted on the AHB side. APB always returns psel=0 for at least that one cycle.
- hrdata holds its last read value until the next successful read.
- pready and pslverr are ignored outside ACCESS.

Test Plan:
- Reset: hresetn=0 for 2 cycles during ACCESS -> next edge psel=0000, penable=0, hr_readyout=1, hresp=00, hrdata=0.
- Write, 0 waits: NONSEQ write haddr=8000_1004, hwdata=DEADBEEF.
  - Required: WDATA, then SETUP with psel=0010, paddr=8000_1004, pwdata=DEADBEEF, pwrite=1.
  - Then ACCESS with penable=1.
  - Then hr_readyout=1, hresp=00.
- Read with 3 waits: haddr=8000_3000, pready low for 3 ACCESS cycles, prdata=12345678.
  - Required: psel=1000, ACCESS lasts 4 cycles, hrdata=12345678 with hr_readyout=1.
- Slave error: read with pslverr=1 on pready -> ERR1 (hresp=01, ready=0), then ERR2 (hresp=01, ready=1); hrdata unchanged.
- Decode miss: write to 8000_4000 (NUM_SLV=4) -> psel never asserted; ERROR two-cycle response.
- Timeout: TIMEOUT=8, pready stuck low -> 8 ACCESS cycles, then ERR1/ERR2. Also cover back-to-back NONSEQ reads and a BUSY transfer (ignored).

Source files
------------

// File: rtl/ahb_apb_bridge_gen2.sv
// AHB-to-APB3 bridge: single AHB transfers become APB SETUP/ACCESS sequences.
// Slave errors, decode misses and pready timeouts all produce the two-cycle AHB ERROR response.
module ahb_apb_bridge_gen2 #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter int                SLV_SHIFT = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                TIMEOUT   = 255
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hwrite,
  input  logic               hready_in,
  input  logic [1:0]         htrans,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  output logic [DATA_W-1:0]  hrdata,
  output logic               hr_readyout,
  output logic [1:0]         hresp,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic               pwrite,
  output logic [ADDR_W-1:0]  paddr,
  output logic [DATA_W-1:0]  pwdata,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_W:0]   REGION     = (ADDR_W + 1)'(NUM_SLV) << SLV_SHIFT;
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [1:0]        RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   timeout_cnt_reg;
  logic [IDX_W-1:0]   haddr_idx;
  logic [ADDR_W-1:0]  offset;
  logic               in_range;
  logic               xfer_valid;
  logic [NUM_SLV-1:0] sel_new;
  logic [NUM_SLV-1:0] sel_held;

  // Unsigned wrap makes addresses below BASE_ADDR land far above REGION.
  assign offset     = haddr - BASE_ADDR;
  assign in_range   = {1'b0, offset} < REGION;
  assign xfer_valid = hready_in && (htrans == 2'b10 || htrans == 2'b11);

  generate
    if (NUM_SLV > 1) begin : g_idx
      assign haddr_idx = haddr[SLV_SHIFT +: IDX_W];
    end else begin : g_idx_single
      assign haddr_idx = '0;
    end

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
      assign sel_new[gi]  = (haddr_idx == IDX_W'(gi));
      assign sel_held[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      timeout_cnt_reg <= '0;
      psel            <= '0;
      penable         <= 1'b0;
      pwrite          <= 1'b0;
      paddr           <= '0;
      pwdata          <= '0;
      hrdata          <= '0;
      hr_readyout     <= 1'b1;
      hresp           <= RESP_OKAY;
    end else begin
      case (state_reg)
        // The completion cycle and ERR2 both take a new address phase.
        S_IDLE, S_ERR2: begin
          if (xfer_valid) begin
            idx_reg     <= haddr_idx;
            hr_readyout <= 1'b0;
            if (!in_range) begin
              state_reg <= S_ERR1;
              hresp     <= RESP_ERROR;
            end else begin
              paddr  <= haddr;
              pwrite <= hwrite;
              hresp  <= RESP_OKAY;
              if (hwrite) begin
                state_reg <= S_WDATA;
              end else begin
                state_reg <= S_SETUP;
                psel      <= sel_new;
              end
            end
          end else begin
            state_reg   <= S_IDLE;
            hr_readyout <= 1'b1;
            hresp       <= RESP_OKAY;
          end
        end

        S_WDATA: begin
          pwdata    <= hwdata;
          psel      <= sel_held;
          state_reg <= S_SETUP;
        end

        S_SETUP: begin
          timeout_cnt_reg <= '0;
          penable         <= 1'b1;
          state_reg       <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready) begin
            psel    <= '0;
            penable <= 1'b0;
            if (pslverr) begin
              state_reg <= S_ERR1;
              hresp     <= RESP_ERROR;
            end else begin
              if (!pwrite) begin
                hrdata <= prdata;
              end
              state_reg   <= S_IDLE;
              hr_readyout <= 1'b1;
            end
          end else if (TIMEOUT != 0 && timeout_cnt_reg == CNT_LAST) begin
            psel      <= '0;
            penable   <= 1'b0;
            state_reg <= S_ERR1;
            hresp     <= RESP_ERROR;
          end else if (TIMEOUT != 0) begin
            timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
          end
        end

        S_ERR1: begin
          state_reg   <= S_ERR2;
          hr_readyout <= 1'b1;
          hresp       <= RESP_ERROR;
        end

        default: begin
          state_reg   <= S_IDLE;
          psel        <= '0;
          penable     <= 1'b0;
          hr_readyout <= 1'b1;
          hresp       <= RESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// Lockstep bench for ahb_apb_bridge_gen2: each transfer's expected cycle timeline is derived
// from its wait count, error flag and address, then compared cycle by cycle.
module tb_ahb_apb_bridge_gen2;

  localparam int          ADDR_W    = 32;
  localparam int          DATA_W    = 32;
  localparam int          NUM_SLV   = 4;
  localparam int          SLV_SHIFT = 12;
  localparam int          TIMEOUT   = 8;
  localparam logic [31:0] BASE      = 32'h8000_0000;

  logic               hclk = 1'b0;
  logic               hresetn;
  logic               hwrite;
  logic               hready_in;
  logic [1:0]         htrans;
  logic [ADDR_W-1:0]  haddr;
  logic [DATA_W-1:0]  hwdata;
  logic [DATA_W-1:0]  hrdata;
  logic               hr_readyout;
  logic [1:0]         hresp;
  logic [NUM_SLV-1:0] psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;
  logic [DATA_W-1:0]  prdata;
  logic               pready;
  logic               pslverr;

  always #5 hclk = ~hclk;

  ahb_apb_bridge_gen2 #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
    .SLV_SHIFT(SLV_SHIFT), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hr_readyout(hr_readyout), .hresp(hresp), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] model_hrdata = 32'h0;
  logic [1:0]  cur_resp = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random bus activity; with allow_valid=0 it never forms an AHB transfer.
  task automatic noise(input bit allow_valid);
    htrans    = 2'($urandom_range(0, 3));
    hready_in = 1'($urandom_range(0, 1));
    if (!allow_valid && htrans[1]) hready_in = 1'b0;
    haddr   = $urandom;
    hwrite  = 1'($urandom_range(0, 1));
    hwdata  = $urandom;
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
  endtask

  task automatic check_ready(input string tag);
    chk({tag, "_ready"},  hr_readyout, 1'b1);
    chk({tag, "_resp"},   hresp, cur_resp);
    chk({tag, "_psel"},   psel, 4'b0000);
    chk({tag, "_pen"},    penable, 1'b0);
    chk({tag, "_hrdata"}, hrdata, model_hrdata);
  endtask

  task automatic check_err1(input string tag);
    chk({tag, "_err1_ready"}, hr_readyout, 1'b0);
    chk({tag, "_err1_resp"},  hresp, 2'b01);
    chk({tag, "_err1_psel"},  psel, 4'b0000);
    chk({tag, "_err1_pen"},   penable, 1'b0);
  endtask

  task automatic idle_cycle(input logic [1:0] tr, input logic rdy);
    check_ready("idle");
    noise(1);
    htrans    = tr;
    hready_in = rdy;
    @(negedge hclk);
    cur_resp = 2'b00;
  endtask

  // One AHB transfer starting at a ready cycle; returns at the next ready cycle.
  task automatic xfer(input string tag, input logic [1:0] tr, input logic [31:0] addr,
                      input logic wr, input logic [31:0] wdata, input int waits,
                      input logic err, input logic [31:0] rdata);
    logic [31:0] off;
    bit          hit, tout;
    int          n_pre, n_acc, j;
    logic [3:0]  exp_sel;
    off     = addr - BASE;
    hit     = off < (32'(NUM_SLV) << SLV_SHIFT);
    exp_sel = 4'b0001 << (off >> SLV_SHIFT);
    tout    = (waits >= TIMEOUT);
    n_acc   = tout ? TIMEOUT : waits + 1;
    n_pre   = wr ? 1 : 0;

    check_ready({tag, "_addr"});
    noise(1);
    htrans = tr; hready_in = 1'b1; haddr = addr; hwrite = wr;
    @(negedge hclk);

    if (!hit) begin
      check_err1(tag);
      noise(1);
      @(negedge hclk);
      cur_resp = 2'b01;
      $display("xfer %s addr=%08h wr=%0d decode-miss", tag, addr, wr);
      return;
    end

    for (int k = 1; k <= n_pre + 1 + n_acc; k++) begin
      chk({tag, "_ready0"}, hr_readyout, 1'b0);
      chk({tag, "_resp0"},  hresp, 2'b00);
      if (k <= n_pre) begin
        chk({tag, "_wdata_psel"}, psel, 4'b0000);
        chk({tag, "_wdata_pen"},  penable, 1'b0);
      end else begin
        chk({tag, "_psel"},   psel, exp_sel);
        chk({tag, "_pen"},    penable, (k > n_pre + 1));
        chk({tag, "_paddr"},  paddr, addr);
        chk({tag, "_pwrite"}, pwrite, wr);
        if (wr) chk({tag, "_pwdata"}, pwdata, wdata);
      end
      noise(1);
      if (wr && k == 1) hwdata = wdata;
      if (k > n_pre + 1) begin
        j       = k - n_pre - 2;
        pready  = (j >= waits);
        if (pready) begin
          pslverr = err;
          prdata  = rdata;
        end
      end
      @(negedge hclk);
    end

    if (tout || err) begin
      check_err1(tag);
      noise(1);
      @(negedge hclk);
      cur_resp = 2'b01;
    end else begin
      cur_resp = 2'b00;
      if (!wr) model_hrdata = rdata;
    end
    $display("xfer %s addr=%08h wr=%0d waits=%0d err=%0d timeout=%0d", tag, addr, wr, waits, err, tout);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn = 1'b0;
    noise(0);
    repeat (3) @(negedge hclk);
    chk("rst_psel",   psel, 4'b0000);
    chk("rst_pen",    penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr",  paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_ready",  hr_readyout, 1'b1);
    chk("rst_resp",   hresp, 2'b00);
    hresetn = 1'b1;
    @(negedge hclk);

    xfer("wr0",     2'b10, 32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    xfer("rd3w",    2'b10, 32'h8000_3000, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678);
    xfer("slverr",  2'b10, 32'h8000_0010, 1'b0, 32'h0, 1, 1'b1, 32'hAAAA_5555);
    xfer("miss",    2'b10, 32'h8000_4000, 1'b1, 32'h5555_AAAA, 0, 1'b0, 32'h0);
    xfer("below",   2'b11, 32'h7FFF_FFFC, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    xfer("tout_rd", 2'b10, 32'h8000_2008, 1'b0, 32'h0, 20, 1'b0, 32'hBAD0_BAD0);
    xfer("tout_wr", 2'b10, 32'h8000_1100, 1'b1, 32'h0F0F_0F0F, 8, 1'b0, 32'h0);
    xfer("w7_rd",   2'b10, 32'h8000_3FFC, 1'b0, 32'h0, 7, 1'b0, 32'hCAFE_F00D);
    xfer("b2b_a",   2'b10, 32'h8000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_2222);
    xfer("b2b_b",   2'b11, 32'h8000_2004, 1'b0, 32'h0, 0, 1'b0, 32'h3333_4444);
    idle_cycle(2'b01, 1'b1);
    idle_cycle(2'b00, 1'b1);
    idle_cycle(2'b10, 1'b0);
    check_ready("after_busy");

    // Reset in the middle of an ACCESS phase.
    noise(1);
    htrans = 2'b10; hready_in = 1'b1; haddr = BASE + 32'h2000; hwrite = 1'b0;
    @(negedge hclk);
    chk("mrst_setup_psel", psel, 4'b0100);
    noise(1);
    @(negedge hclk);
    chk("mrst_access_pen", penable, 1'b1);
    noise(1);
    pready  = 1'b0;
    hresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      chk("mrst_psel",   psel, 4'b0000);
      chk("mrst_pen",    penable, 1'b0);
      chk("mrst_ready",  hr_readyout, 1'b1);
      chk("mrst_resp",   hresp, 2'b00);
      chk("mrst_hrdata", hrdata, 32'h0);
      noise(0);
    end
    hresetn      = 1'b1;
    model_hrdata = 32'h0;
    cur_resp     = 2'b00;
    @(negedge hclk);
    $display("reset during ACCESS applied");

    for (int t = 0; t < 60; t++) begin
      int          r, waits, gaps;
      logic [31:0] addr;
      logic        wr, err;
      logic [1:0]  tr;
      r = $urandom_range(0, 5);
      if (r < 4)       addr = BASE | (32'(r) << SLV_SHIFT) | (32'($urandom_range(0, 1023)) << 2);
      else if (r == 4) addr = BASE + 32'h4000 + (32'($urandom_range(0, 4095)) << 2);
      else             addr = $urandom & 32'h7FFF_FFFF;
      wr    = 1'($urandom_range(0, 1));
      err   = ($urandom_range(0, 4) == 0);
      waits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
      tr    = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      xfer($sformatf("rnd%0d", t), tr, addr, wr, $urandom, waits, err, $urandom);
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        r = $urandom_range(0, 2);
        if (r == 0)      idle_cycle(2'b00, 1'b1);
        else if (r == 1) idle_cycle(2'b01, 1'b1);
        else             idle_cycle(2'b11, 1'b0);
      end
    end
    check_ready("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
